receptor_display_multiplexado: RTL and testbench
================================================

Name: receptor_display_multiplexado

Overview:
Receive-side counterpart of the three-digit multiplexed 7-segment display bus (7 segment lines plus 3 active-low anodes).
- Samples the scanned bus.
- Qualifies each digit dwell for stability and decodes each segment pattern back to a decimal digit.
- Reassembles units/tens/hundreds into a binary count 0..999, with a one-cycle valid strobe per complete frame.
- Used on-chip as a loopback checker for the display driver, or as an input block reading an external multiplexed display.

Parameters:
- ESTABLE_CICLOS, 4: consecutive identical samples required before a dwell is accepted (legal range 2..65535).
- ANCHO_ESTABLE, 16: width of the stability counter.

Ports:
- reloj  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines; bit6=a … bit0=g; 1 = segment lit.
- an_in  in  3  anode lines, active-low: 110 units, 101 tens, 011 hundreds, 111 blank.
- cuenta_out  out  10  last complete frame value c*100+d*10+u.
- digitos_out  out  12  {cen[3:0], dec[3:0], uni[3:0]} of the last complete frame.
- valido  out  1  one-cycle pulse when cuenta_out/digitos_out update.
- err_segmento  out  1  one-cycle pulse when an accepted dwell carries a non-digit pattern.
- err_anodo  out  1  one-cycle pulse when an accepted dwell has more than one anode low.

Behaviour:
- Reset (reset=1 at a clock edge):
  - Outputs: cuenta_out=0, digitos_out=0, valido=0, err_segmento=0, err_anodo=0.
  - Internals: sample register=7'b0/3'b111, stability counter=0, FSM=ESPERA_UNI, partial digits cleared.
  - Reset asserted mid-frame discards all partial captures; no valido is produced for that frame.
- Input stage:
  - {an_in, seg_in} is registered once into muestra; no synchronizer is inside this block.
  - muestra != previous muestra: counter <= 0. Otherwise the counter increments, saturating at all-ones.
- Dwell acceptance:
  - Fires exactly once per dwell, on the cycle the counter transitions to ESTABLE_CICLOS-1, i.e. muestra unchanged for ESTABLE_CICLOS consecutive cycles.
  - Glitches shorter than that are ignored.
  - A dwell longer than the threshold is not re-accepted.
- Anode classification of an accepted dwell:
  - 111 (blank): ignored; FSM holds.
  - One-cold (110/101/011): digit position UNI/DEC/CEN.
  - Any pattern with two or more zeros: err_anodo pulses the next cycle; FSM -> ESPERA_UNI.
- Segment decode, exact match only:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other pattern on a one-cold dwell: err_segmento pulses the next cycle; FSM -> ESPERA_UNI.
- FSM, accepted valid digits only:
  - ESPERA_UNI: UNI -> store u, go TIENE_UNI. DEC/CEN -> stay (out-of-phase start).
  - TIENE_UNI: DEC -> store d, go TIENE_DEC. UNI -> overwrite u, stay. CEN -> ESPERA_UNI.
  - TIENE_DEC: CEN -> store c, go COMPONER. UNI -> overwrite u, go TIENE_UNI. DEC -> overwrite d, stay.
  - COMPONER (one cycle): cuenta_out <= c*100+d*10+u, digitos_out <= {c,d,u}, valido=1, next ESPERA_UNI.
  - An acceptance event arriving in the COMPONER cycle cannot occur, since the minimum dwell is ≥2 cycles.
- Latency: valido rises 2 cycles after the hundreds dwell is accepted (acceptance cycle -> COMPONER register -> output).
- Arithmetic: c*100 built as (c<<6)+(c<<5)+(c<<2); max 999 fits 10 bits. Leading-zero digits decode normally (e.g. 007).
- Simultaneous events: reset dominates all. Error pulses and valido are mutually exclusive by construction.

Decomposition:
- Package paquete_display:
  - 7-bit segment constants SEG_0..SEG_9.
  - Anode constants AN_UNI=3'b110, AN_DEC=3'b101, AN_CEN=3'b011, AN_BLANK=3'b111.
  - Enum estado_rx_t {ESPERA_UNI, TIENE_UNI, TIENE_DEC, COMPONER}.
- Sub-module decodificador_segmentos:
  - Combinational seg[6:0] -> digito[3:0] plus es_digito flag.
  - Shared with future test blocks.
- The stability counter and FSM stay in the top of this block.

Test Plan:
- Scan 255: 8 cycles each of (110,1011011), (101,1011011), (011,1101101), (111,0000000); expect valido once, cuenta_out=255, digitos_out=12'h255.
- Glitch rejection, ESTABLE_CICLOS=4: insert a 3-cycle (101,0110000) between a valid frame's UNI and DEC dwells; expect no acceptance of it and the final value unchanged from the clean frame.
- Out-of-phase start: begin stimulus at the DEC dwell of frame "042"; expect no valido until the next full frame, then cuenta_out=42, digitos_out=12'h042.
- Bad pattern: UNI dwell with seg 1000001; expect err_segmento single pulse, no valido for that frame, recovery on the following clean frame (e.g. 999 -> cuenta_out=999).
- Anode fault: dwell with an_in=100; expect err_anodo single pulse, FSM back to ESPERA_UNI.
- Reset mid-frame: assert reset for 1 cycle after UNI and DEC of "123" are captured; expect all outputs 0 and no valido until a fresh complete frame.

Source files
------------

// File: rtl/receptor_display_multiplexado_pkg.sv
// Shared encodings for the multiplexed 7-segment display bus: segment patterns,
// anode selects and receiver FSM states.
package paquete_display;

  // bit6=a ... bit0=g, 1 = segment lit
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [2:0] AN_UNI   = 3'b110;
  localparam logic [2:0] AN_DEC   = 3'b101;
  localparam logic [2:0] AN_CEN   = 3'b011;
  localparam logic [2:0] AN_BLANK = 3'b111;

  typedef enum logic [1:0] {ESPERA_UNI, TIENE_UNI, TIENE_DEC, COMPONER} estado_rx_t;

endpackage

// File: rtl/receptor_display_multiplexado_decodificador.sv
// Exact-match 7-segment to decimal decoder; anything not a digit clears es_digito.
module decodificador_segmentos
  import paquete_display::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digito,
  output logic       es_digito
);

  always_comb begin
    digito    = 4'd0;
    es_digito = 1'b1;
    case (seg)
      SEG_0:   digito = 4'd0;
      SEG_1:   digito = 4'd1;
      SEG_2:   digito = 4'd2;
      SEG_3:   digito = 4'd3;
      SEG_4:   digito = 4'd4;
      SEG_5:   digito = 4'd5;
      SEG_6:   digito = 4'd6;
      SEG_7:   digito = 4'd7;
      SEG_8:   digito = 4'd8;
      SEG_9:   digito = 4'd9;
      default: es_digito = 1'b0;
    endcase
  end

endmodule

// File: rtl/receptor_display_multiplexado.sv
// Receiver for a 3-digit multiplexed 7-segment bus: qualifies stable dwells,
// decodes digits and reassembles hundreds/tens/units into a 0..999 count.
module receptor_display_multiplexado
  import paquete_display::*;
#(
  parameter int ESTABLE_CICLOS = 4,
  parameter int ANCHO_ESTABLE  = 16
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [2:0]  an_in,
  output logic [9:0]  cuenta_out,
  output logic [11:0] digitos_out,
  output logic        valido,
  output logic        err_segmento,
  output logic        err_anodo
);

  localparam logic [ANCHO_ESTABLE-1:0] UMBRAL = ANCHO_ESTABLE'(ESTABLE_CICLOS - 1);

  logic [9:0]               r_muestra;
  logic [ANCHO_ESTABLE-1:0] r_cnt;
  logic [2:0]               w_an;
  logic [6:0]               w_seg;
  logic [3:0]               w_digito;
  logic                     w_es_digito;
  logic                     w_acepta;

  estado_rx_t r_estado, w_estado_sig;
  logic [3:0] r_uni, r_dec, r_cen;
  logic       w_ld_u, w_ld_d, w_ld_c, w_valido, w_err_seg, w_err_an;
  logic [9:0] w_u10, w_d10, w_c10, w_cuenta;

  // The counter tracks how long the current sample has been held; it equals
  // UMBRAL for exactly one cycle per dwell, which is the acceptance strobe.
  always_ff @(posedge reloj) begin
    if (reset) begin
      r_muestra <= {AN_BLANK, 7'b0};
      r_cnt     <= '0;
    end else begin
      r_muestra <= {an_in, seg_in};
      if ({an_in, seg_in} != r_muestra) r_cnt <= '0;
      else if (r_cnt != '1)             r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_an     = r_muestra[9:7];
  assign w_seg    = r_muestra[6:0];
  assign w_acepta = (r_cnt == UMBRAL);

  decodificador_segmentos u_dec (
    .seg       (w_seg),
    .digito    (w_digito),
    .es_digito (w_es_digito)
  );

  always_comb begin
    w_estado_sig = r_estado;
    w_ld_u       = 1'b0;
    w_ld_d       = 1'b0;
    w_ld_c       = 1'b0;
    w_valido     = 1'b0;
    w_err_seg    = 1'b0;
    w_err_an     = 1'b0;
    if (r_estado == COMPONER) begin
      w_valido     = 1'b1;
      w_estado_sig = ESPERA_UNI;
    end else if (w_acepta) begin
      case (w_an)
        AN_BLANK: ;
        AN_UNI, AN_DEC, AN_CEN: begin
          if (!w_es_digito) begin
            w_err_seg    = 1'b1;
            w_estado_sig = ESPERA_UNI;
          end else begin
            case (r_estado)
              ESPERA_UNI: if (w_an == AN_UNI) begin
                w_ld_u = 1'b1; w_estado_sig = TIENE_UNI;
              end
              TIENE_UNI: begin
                if (w_an == AN_DEC)      begin w_ld_d = 1'b1; w_estado_sig = TIENE_DEC; end
                else if (w_an == AN_UNI) w_ld_u = 1'b1;
                else                     w_estado_sig = ESPERA_UNI;
              end
              TIENE_DEC: begin
                if (w_an == AN_CEN)      begin w_ld_c = 1'b1; w_estado_sig = COMPONER; end
                else if (w_an == AN_UNI) begin w_ld_u = 1'b1; w_estado_sig = TIENE_UNI; end
                else                     w_ld_d = 1'b1;
              end
              default: w_estado_sig = ESPERA_UNI;
            endcase
          end
        end
        default: begin
          w_err_an     = 1'b1;
          w_estado_sig = ESPERA_UNI;
        end
      endcase
    end
  end

  // c*100 + d*10 + u using shifts only
  assign w_u10    = {6'b0, r_uni};
  assign w_d10    = {6'b0, r_dec};
  assign w_c10    = {6'b0, r_cen};
  assign w_cuenta = (w_c10 << 6) + (w_c10 << 5) + (w_c10 << 2)
                  + (w_d10 << 3) + (w_d10 << 1) + w_u10;

  always_ff @(posedge reloj) begin
    if (reset) begin
      r_estado     <= ESPERA_UNI;
      r_uni        <= 4'd0;
      r_dec        <= 4'd0;
      r_cen        <= 4'd0;
      cuenta_out   <= 10'd0;
      digitos_out  <= 12'd0;
      valido       <= 1'b0;
      err_segmento <= 1'b0;
      err_anodo    <= 1'b0;
    end else begin
      r_estado     <= w_estado_sig;
      if (w_ld_u) r_uni <= w_digito;
      if (w_ld_d) r_dec <= w_digito;
      if (w_ld_c) r_cen <= w_digito;
      valido       <= w_valido;
      err_segmento <= w_err_seg;
      err_anodo    <= w_err_an;
      if (w_valido) begin
        cuenta_out  <= w_cuenta;
        digitos_out <= {r_cen, r_dec, r_uni};
      end
    end
  end

endmodule

// File: tb/tb_receptor_display_multiplexado.sv
// Bench for receptor_display_multiplexado: directed scenarios plus random frames,
// compared every cycle against a dwell/event-history model of the receiver.
module tb_receptor_display_multiplexado;

  localparam int ES = 4;

  logic        reloj = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = 7'b0;
  logic [2:0]  an_in = 3'b111;
  logic [9:0]  cuenta_out;
  logic [11:0] digitos_out;
  logic        valido, err_segmento, err_anodo;

  receptor_display_multiplexado #(.ESTABLE_CICLOS(ES), .ANCHO_ESTABLE(16)) dut (
    .reloj        (reloj),
    .reset        (reset),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .cuenta_out   (cuenta_out),
    .digitos_out  (digitos_out),
    .valido       (valido),
    .err_segmento (err_segmento),
    .err_anodo    (err_anodo)
  );

  always #5 reloj = ~reloj;

  logic [6:0] tabla [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int checks = 0;
  int errors = 0;
  int n_val = 0, n_es = 0, n_ea = 0;

  // Model: run length of the raw input, plus history of accepted digit events
  typedef struct { bit d; logic [3:0] v; } ev_t;
  typedef struct { bit es; bit ea; bit v; logic [9:0] cu; logic [11:0] dg; } slot_t;
  ev_t        hist[$];
  slot_t      s1, s2;
  logic [9:0] m_prev;
  int         m_run;
  logic       e_val, e_es, e_ea;
  logic [9:0] e_cu;
  logic [11:0] e_dg;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic slot_t vacio();
    slot_t z;
    z.es = 0; z.ea = 0; z.v = 0; z.cu = '0; z.dg = '0;
    return z;
  endfunction

  task automatic aceptar(input logic [2:0] an, input logic [6:0] seg);
    int dig = -1;
    int n, i;
    logic [3:0] u, d;
    for (int k = 0; k < 10; k++) if (tabla[k] == seg) dig = k;
    if (an == 3'b111) return;
    if (3 - $countones(an) >= 2) begin s1.ea = 1; hist.delete(); return; end
    if (dig < 0) begin s1.es = 1; hist.delete(); return; end
    if (an == 3'b110)      hist.push_back('{d: 1'b0, v: 4'(dig)});
    else if (an == 3'b101) hist.push_back('{d: 1'b1, v: 4'(dig)});
    else begin
      // hundreds completes a frame only if it directly follows a units then tens run
      n = hist.size();
      if (n > 0 && hist[n-1].d) begin
        i = n - 1;
        while (i >= 0 && hist[i].d) i--;
        if (i >= 0) begin
          u = hist[i].v;
          d = hist[n-1].v;
          s2.v  = 1;
          s2.cu = 10'(dig * 100 + int'(d) * 10 + int'(u));
          s2.dg = {4'(dig), d, u};
        end
      end
      hist.delete();
    end
  endtask

  task automatic model_edge(input logic [2:0] an, input logic [6:0] seg, input logic rst);
    if (rst) begin
      e_val = 0; e_es = 0; e_ea = 0; e_cu = '0; e_dg = '0;
      s1 = vacio(); s2 = vacio();
      hist.delete();
      m_prev = {3'b111, 7'b0};
      m_run  = 1;
      return;
    end
    e_val = s1.v; e_es = s1.es; e_ea = s1.ea;
    if (s1.v) begin e_cu = s1.cu; e_dg = s1.dg; end
    s1 = s2;
    s2 = vacio();
    if ({an, seg} == m_prev) m_run++;
    else begin m_run = 1; m_prev = {an, seg}; end
    if (m_run == ES) aceptar(an, seg);
  endtask

  task automatic step(input logic [2:0] an, input logic [6:0] seg, input logic rst);
    an_in = an; seg_in = seg; reset = rst;
    @(posedge reloj);
    model_edge(an, seg, rst);
    @(negedge reloj);
    chk("valido",       {11'b0, valido},       {11'b0, e_val});
    chk("err_segmento", {11'b0, err_segmento}, {11'b0, e_es});
    chk("err_anodo",    {11'b0, err_anodo},    {11'b0, e_ea});
    chk("cuenta_out",   {2'b0, cuenta_out},    {2'b0, e_cu});
    chk("digitos_out",  digitos_out,           e_dg);
    if (valido)       n_val++;
    if (err_segmento) n_es++;
    if (err_anodo)    n_ea++;
  endtask

  task automatic dwell(input logic [2:0] an, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(an, seg, 1'b0);
  endtask

  task automatic frame(input int c, input int d, input int u, input int n);
    dwell(3'b110, tabla[u], n);
    dwell(3'b101, tabla[d], n);
    dwell(3'b011, tabla[c], n);
    dwell(3'b111, 7'b0, n);
  endtask

  task automatic clr();
    n_val = 0; n_es = 0; n_ea = 0;
  endtask

  initial begin
    int c, d, u, l1, l2, l3, modo;
    step(3'b111, 7'b0, 1'b1);
    step(3'b111, 7'b0, 1'b1);
    chk("reset cuenta", {2'b0, cuenta_out}, 12'd0);
    chk("reset valido", {11'b0, valido}, 12'd0);

    // scan 255
    clr();
    dwell(3'b110, 7'b1011011, 8);
    dwell(3'b101, 7'b1011011, 8);
    dwell(3'b011, 7'b1101101, 8);
    dwell(3'b111, 7'b0000000, 8);
    chk("scan255 pulses", 12'(n_val), 12'd1);
    chk("scan255 cuenta", {2'b0, cuenta_out}, 12'd255);
    chk("scan255 digitos", digitos_out, 12'h255);
    chk("scan255 model", {2'b0, e_cu}, 12'd255);

    // glitch between units and tens
    clr();
    dwell(3'b110, tabla[1], 8);
    dwell(3'b101, 7'b0110000, 3);
    dwell(3'b101, tabla[8], 8);
    dwell(3'b011, tabla[3], 8);
    dwell(3'b111, 7'b0, 8);
    chk("glitch pulses", 12'(n_val), 12'd1);
    chk("glitch cuenta", {2'b0, cuenta_out}, 12'd381);

    // out-of-phase start at tens of 042
    clr();
    dwell(3'b101, tabla[4], 8);
    dwell(3'b011, tabla[0], 8);
    dwell(3'b111, 7'b0, 8);
    chk("fase partial pulses", 12'(n_val), 12'd0);
    frame(0, 4, 2, 8);
    chk("fase pulses", 12'(n_val), 12'd1);
    chk("fase cuenta", {2'b0, cuenta_out}, 12'd42);
    chk("fase digitos", digitos_out, 12'h042);

    // non-digit units pattern
    clr();
    dwell(3'b110, 7'b1000001, 8);
    dwell(3'b101, tabla[9], 8);
    dwell(3'b011, tabla[9], 8);
    dwell(3'b111, 7'b0, 8);
    chk("badseg err pulses", 12'(n_es), 12'd1);
    chk("badseg valid pulses", 12'(n_val), 12'd0);
    frame(9, 9, 9, 8);
    chk("badseg recover", {2'b0, cuenta_out}, 12'd999);

    // two anodes low after a captured units digit
    clr();
    dwell(3'b110, tabla[7], 8);
    dwell(3'b100, tabla[5], 8);
    dwell(3'b101, tabla[0], 8);
    dwell(3'b011, tabla[0], 8);
    dwell(3'b111, 7'b0, 8);
    chk("anodo err pulses", 12'(n_ea), 12'd1);
    chk("anodo valid pulses", 12'(n_val), 12'd0);

    // reset mid-frame of 123
    clr();
    dwell(3'b110, tabla[3], 8);
    dwell(3'b101, tabla[2], 8);
    step(3'b101, tabla[2], 1'b1);
    dwell(3'b011, tabla[1], 8);
    dwell(3'b111, 7'b0, 8);
    chk("rstmid pulses", 12'(n_val), 12'd0);
    chk("rstmid cuenta", {2'b0, cuenta_out}, 12'd0);
    frame(1, 2, 3, 8);
    chk("rstmid recover", {2'b0, cuenta_out}, 12'd123);

    // leading zeros, minimum-length dwells
    frame(0, 0, 7, ES);
    chk("007 digitos", digitos_out, 12'h007);
    chk("007 cuenta", {2'b0, cuenta_out}, 12'd7);

    // random frames with occasional faults
    for (int f = 0; f < 60; f++) begin
      c = $urandom_range(0, 9); d = $urandom_range(0, 9); u = $urandom_range(0, 9);
      l1 = $urandom_range(2, 9); l2 = $urandom_range(2, 9); l3 = $urandom_range(2, 9);
      modo = $urandom_range(0, 9);
      if (modo == 0) dwell(3'b110, 7'($urandom), l1);
      else           dwell(3'b110, tabla[u], l1);
      if (modo == 1) dwell(3'($urandom), tabla[d], l2);
      else           dwell(3'b101, tabla[d], l2);
      if (modo == 2) step(3'b101, tabla[d], 1'b1);
      if (modo == 3) dwell(3'b110, tabla[$urandom_range(0, 9)], l1);
      dwell(3'b011, tabla[c], l3);
      dwell(3'b111, 7'b0, $urandom_range(1, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
